// File: rtl/tlb_refill_walker.sv
// TLB miss handler: reads one PTE from a single-level page table, picks a
// victim way in the missing set, writes the refill, then reports done/fault.
module tlb_refill_walker #(
    parameter int NUM_WAYS       = 4,
    parameter int SET_INDEX_BITS = 4,
    parameter int NUM_SETS       = 2**SET_INDEX_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      miss_valid,
    output logic                      miss_ready,
    input  logic [19:0]               miss_vpn,
    input  logic [NUM_WAYS-1:0]       set_valid,
    input  logic [31:0]               ptbr,
    output logic                      mem_req_valid,
    output logic [31:0]               mem_req_addr,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic [31:0]               mem_resp_data,
    output logic                      refill_valid,
    output logic [SET_INDEX_BITS-1:0] refill_set,
    output logic [1:0]                refill_way,
    output logic [19:0]               refill_vpn,
    output logic [19:0]               refill_ppn,
    output logic [1:0]                refill_perms,
    output logic                      done_valid,
    output logic                      done_fault
);

    localparam int WAY_BITS = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        REFILL,
        DONE
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [19:0]               vpn_q;
    logic [NUM_WAYS-1:0]       setv_q;
    logic [19:0]               ppn_q;
    logic [1:0]                perms_q;
    logic                      fault_q;
    logic [WAY_BITS-1:0]       rr_ptr [NUM_SETS];
    logic [SET_INDEX_BITS-1:0] set_idx;
    logic [WAY_BITS-1:0]       victim;
    logic                      all_valid;
    logic                      unused_pte_bits;

    assign set_idx         = vpn_q[SET_INDEX_BITS-1:0];
    assign all_valid       = &setv_q;
    assign unused_pte_bits = ^mem_resp_data[11:3];

    // Prefer an empty way; round-robin only when the set is full.
    always_comb begin
        victim = rr_ptr[set_idx];
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!setv_q[i]) begin
                victim = WAY_BITS'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        refill_valid  = 1'b0;
        done_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_d = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d = mem_resp_data[0] ? REFILL : DONE;
                end
            end
            REFILL: begin
                refill_valid = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_addr = mem_req_valid ? ptbr + {10'b0, vpn_q, 2'b00} : '0;
    assign refill_set   = refill_valid ? set_idx : '0;
    assign refill_way   = refill_valid ? 2'(victim) : '0;
    assign refill_vpn   = refill_valid ? vpn_q : '0;
    assign refill_ppn   = refill_valid ? ppn_q : '0;
    assign refill_perms = refill_valid ? perms_q : '0;
    assign done_fault   = done_valid & fault_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vpn_q   <= '0;
            setv_q  <= '0;
            ppn_q   <= '0;
            perms_q <= '0;
            fault_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && miss_valid) begin
                vpn_q  <= miss_vpn;
                setv_q <= set_valid;
            end
            if (state_q == WAIT && mem_resp_valid) begin
                ppn_q   <= mem_resp_data[31:12];
                perms_q <= mem_resp_data[2:1];
                fault_q <= ~mem_resp_data[0];
            end
            if (state_q == REFILL && all_valid) begin
                rr_ptr[set_idx] <= rr_ptr[set_idx] + 1'b1;
            end
        end
    end

endmodule
